// File: rtl/mdu_iter_pkg.sv
`default_nettype none
// mdu_iter_pkg: shared op/state encodings and helpers for the iterative RV32M unit (rev 1.0).
package mdu_iter_pkg;

   localparam int   XLEN_DEF   = 32;
   localparam logic RST_ACTIVE = 1'b0;

   typedef enum logic [2:0] {
      MDU_MUL    = 3'd0,
      MDU_MULH   = 3'd1,
      MDU_MULHSU = 3'd2,
      MDU_MULHU  = 3'd3,
      MDU_DIV    = 3'd4,
      MDU_DIVU   = 3'd5,
      MDU_REM    = 3'd6,
      MDU_REMU   = 3'd7
   } mdu_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } mdu_state_e;

   function automatic logic op_is_div(input mdu_op_e op);
      return op inside {MDU_DIV, MDU_DIVU, MDU_REM, MDU_REMU};
   endfunction

   function automatic logic op_is_rem(input mdu_op_e op);
      return op inside {MDU_REM, MDU_REMU};
   endfunction

   function automatic logic rs1_signed(input mdu_op_e op);
      return op inside {MDU_MUL, MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM};
   endfunction

   function automatic logic rs2_signed(input mdu_op_e op);
      return op inside {MDU_MUL, MDU_MULH, MDU_DIV, MDU_REM};
   endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_div_step.sv
`default_nettype none
// mdu_div_step: one combinational restoring-division step (rev 1.0).
module mdu_div_step
   import mdu_iter_pkg::*;
#(
   parameter int XLEN = XLEN_DEF
) (
   input  logic [XLEN-1:0] rem_in,
   input  logic            bit_in,
   input  logic [XLEN-1:0] divisor,
   output logic [XLEN-1:0] rem_out,
   output logic            q_bit
);

   logic [XLEN:0] shifted;
   logic [XLEN:0] diff;

   // rem_in < divisor, so the shifted value fits XLEN+1 bits and a borrow shows in the MSB
   assign shifted = {rem_in, bit_in};
   assign diff    = shifted - {1'b0, divisor};
   assign q_bit   = ~diff[XLEN];
   assign rem_out = q_bit ? diff[XLEN-1:0] : shifted[XLEN-1:0];

endmodule
`default_nettype wire

// File: rtl/mdu_iter.sv
`default_nettype none
// mdu_iter: iterative RV32M multiply/divide unit, one op in flight (rev 1.0).
// Define MDU_FAST_MUL_EN for single-cycle multiplies inside CALC.
module mdu_iter
   import mdu_iter_pkg::*;
#(
   parameter int XLEN  = XLEN_DEF,
   parameter int CNT_W = 6
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] src1,
   input  logic [XLEN-1:0] src2,
   input  logic [4:0]      rd_in,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic [4:0]      rd_out,
   output logic            busy
);

   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   mdu_state_e      state, state_nxt;
   mdu_op_e         op_in, op_q;
   logic [CNT_W-1:0] cnt;
   logic [XLEN-1:0] acc_q, lo_q, mag_q;
   logic            neg_q, special_q;

   logic            accept, s1_neg, s2_neg, div_zero, div_ovf, special, neg_in, calc_last;
   logic [XLEN-1:0] mag1, mag2, special_val, div_rem, quo_s, rem_s, fix_val;
   logic            div_q;
   logic [2*XLEN-1:0] prod, prod_s;

   assign op_in     = mdu_op_e'(op);
   assign in_ready  = (rst != RST_ACTIVE) && (state == IDLE) && !flush;
   assign accept    = in_valid && in_ready;
   assign busy      = (state != IDLE);
   assign out_valid = (state == DONE);

   assign s1_neg   = rs1_signed(op_in) && src1[XLEN-1];
   assign s2_neg   = rs2_signed(op_in) && src2[XLEN-1];
   assign mag1     = s1_neg ? -src1 : src1;
   assign mag2     = s2_neg ? -src2 : src2;
   assign div_zero = op_is_div(op_in) && (src2 == '0);
   assign div_ovf  = (op_in == MDU_DIV || op_in == MDU_REM) && (src1 == MIN_NEG) && (src2 == '1);
   assign special  = div_zero || div_ovf;
   assign neg_in   = op_is_rem(op_in) ? s1_neg : (s1_neg ^ s2_neg);

   always_comb begin
      special_val = '0;
      if (div_zero)
         special_val = op_is_rem(op_in) ? src1 : '1;
      else
         special_val = op_is_rem(op_in) ? '0 : MIN_NEG;
   end

   mdu_div_step #(.XLEN(XLEN)) u_div_step (
      .rem_in  (acc_q),
      .bit_in  (lo_q[XLEN-1]),
      .divisor (mag_q),
      .rem_out (div_rem),
      .q_bit   (div_q)
   );

`ifdef MDU_FAST_MUL_EN
   logic [2*XLEN-1:0] fast_prod;
   assign fast_prod = {{XLEN{1'b0}}, lo_q} * {{XLEN{1'b0}}, mag_q};
   assign calc_last = (cnt == '0) || !op_is_div(op_q);
`else
   // Shift-add: {acc_q, lo_q} holds {partial product, remaining multiplier bits}
   logic [XLEN:0] mul_sum;
   assign mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, mag_q} : '0);
   assign calc_last = (cnt == '0);
`endif

   assign prod   = {acc_q, lo_q};
   assign prod_s = neg_q ? -prod : prod;
   assign quo_s  = neg_q ? -lo_q : lo_q;
   assign rem_s  = neg_q ? -acc_q : acc_q;

   always_comb begin
      fix_val = '0;
      if (special_q) begin
         fix_val = acc_q;
      end else begin
         case (op_q)
            MDU_MUL:                         fix_val = prod_s[XLEN-1:0];
            MDU_MULH, MDU_MULHSU, MDU_MULHU: fix_val = prod_s[2*XLEN-1:XLEN];
            MDU_DIV, MDU_DIVU:               fix_val = quo_s;
            default:                         fix_val = rem_s;
         endcase
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = special ? FIX : CALC;
         CALC:    if (calc_last) state_nxt = FIX;
         FIX:     state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (flush) state_nxt = IDLE;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (rst == RST_ACTIVE) state <= IDLE;
      else                   state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (rst == RST_ACTIVE) begin
         op_q      <= MDU_MUL;
         cnt       <= '0;
         acc_q     <= '0;
         lo_q      <= '0;
         mag_q     <= '0;
         neg_q     <= 1'b0;
         special_q <= 1'b0;
         result    <= '0;
         rd_out    <= '0;
      end else begin
         if (accept) begin
            op_q      <= op_in;
            rd_out    <= rd_in;
            neg_q     <= neg_in;
            special_q <= special;
            acc_q     <= special ? special_val : '0;
            lo_q      <= mag1;
            mag_q     <= mag2;
            cnt       <= CNT_W'(XLEN-1);
         end else if (state == CALC && !flush) begin
            if (op_is_div(op_q)) begin
               acc_q <= div_rem;
               lo_q  <= {lo_q[XLEN-2:0], div_q};
            end else begin
`ifdef MDU_FAST_MUL_EN
               {acc_q, lo_q} <= fast_prod;
`else
               acc_q <= mul_sum[XLEN:1];
               lo_q  <= {mul_sum[0], lo_q[XLEN-1:1]};
`endif
            end
            if (cnt != '0) cnt <= cnt - CNT_W'(1);
         end else if (flush) begin
            cnt <= '0;
         end
         if (state == FIX && !flush) result <= fix_val;
      end
   end

endmodule
`default_nettype wire
